vx_alu_packet_split: RTL and testbench

Splits one full-warp ALU dispatch request (`NUM_THREADS` lanes) into a sequence of `NUM_LANES`-wide execute packets tagged with packet id and start/end-of-packet flags. It skips lane slices whose thread mask is empty. It sits directly upstream of the ALU block execute inputs, on the partial-bandwidth path where `NUM_LANES < NUM_THREADS`. It produces the `pid`/`sop`/`eop` sideband that the ALU sub-units carry through to commit.

---
 rtl/vx_alu_packet_split.sv | 124 ++++++++++++
 tb/tb_vx_alu_packet_split.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vx_alu_packet_split.sv
// rtl/vx_alu_packet_split.sv - splits a full-warp ALU request into NUM_LANES-wide packets
// Empty lane slices are skipped. An all-zero warp still emits one packet so it reaches commit.
module vx_alu_packet_split #(
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 2,
  parameter int HDR_W       = 64,
  parameter int LANE_W      = 96,
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES,
  localparam int PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_THREADS-1:0]        in_tmask,
  input  logic [HDR_W-1:0]              in_hdr,
  input  logic [NUM_THREADS*LANE_W-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_LANES-1:0]          out_tmask,
  output logic [HDR_W-1:0]              out_hdr,
  output logic [NUM_LANES*LANE_W-1:0]   out_data,
  output logic [PID_WIDTH-1:0]          out_pid,
  output logic                          out_sop,
  output logic                          out_eop
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t state, state_next;

  logic [NUM_THREADS-1:0]        buf_tmask;
  logic [HDR_W-1:0]              buf_hdr;
  logic [NUM_THREADS*LANE_W-1:0] buf_data;
  logic [PID_WIDTH-1:0]          pid;
  logic                          sop;

  logic [NUM_PACKETS-1:0] in_nz;
  logic [NUM_PACKETS-1:0] buf_nz;
  logic [PID_WIDTH-1:0]   first_pid;
  logic [PID_WIDTH-1:0]   next_pid;
  logic                   has_next;
  logic                   accept;
  logic                   fire;

  function automatic logic [NUM_PACKETS-1:0] slice_nz(input logic [NUM_THREADS-1:0] m);
    for (int k = 0; k < NUM_PACKETS; k++) begin
      slice_nz[k] = |m[k*NUM_LANES +: NUM_LANES];
    end
  endfunction

  assign in_nz  = slice_nz(in_tmask);
  assign buf_nz = slice_nz(buf_tmask);

  // Descending scans so the lowest qualifying slice index wins.
  always_comb begin
    first_pid = '0;
    next_pid  = pid;
    has_next  = 1'b0;
    for (int k = NUM_PACKETS - 1; k >= 0; k--) begin
      if (in_nz[k]) begin
        first_pid = PID_WIDTH'(k);
      end
      if (buf_nz[k] && (k > int'(pid))) begin
        next_pid = PID_WIDTH'(k);
        has_next = 1'b1;
      end
    end
  end

  assign out_eop   = !has_next;
  assign out_pid   = pid;
  assign out_sop   = sop;
  assign out_hdr   = buf_hdr;
  assign out_tmask = buf_tmask[int'(pid)*NUM_LANES +: NUM_LANES];
  assign out_data  = buf_data[int'(pid)*NUM_LANES*LANE_W +: NUM_LANES*LANE_W];

  always_comb begin
    state_next = state;
    out_valid  = (state == ISSUE);
    fire       = out_valid && out_ready;
    in_ready   = (state == IDLE) || (fire && out_eop);
    accept     = in_valid && in_ready;
    if (accept) begin
      state_next = ISSUE;
    end else if (fire && out_eop) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_tmask <= '0;
      buf_hdr   <= '0;
      buf_data  <= '0;
      pid       <= '0;
      sop       <= 1'b0;
    end else if (accept) begin
      buf_tmask <= in_tmask;
      buf_hdr   <= in_hdr;
      buf_data  <= in_data;
      pid       <= first_pid;
      sop       <= 1'b1;
    end else if (fire) begin
      // On the eop handshake pid stays put; only sop drops.
      if (!out_eop) begin
        pid <= next_pid;
      end
      sop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vx_alu_packet_split.sv
// tb/tb_vx_alu_packet_split.sv - directed bench for vx_alu_packet_split
// Inputs change and outputs are sampled on the falling edge.
module tb_vx_alu_packet_split;

  localparam int NT = 8;
  localparam int NL = 2;
  localparam int HW = 64;
  localparam int LW = 96;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [NT-1:0]   in_tmask;
  logic [HW-1:0]   in_hdr;
  logic [NT*LW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [NL-1:0]   out_tmask;
  logic [HW-1:0]   out_hdr;
  logic [NL*LW-1:0] out_data;
  logic [1:0]      out_pid;
  logic            out_sop;
  logic            out_eop;

  int checks   = 0;
  int failures = 0;

  vx_alu_packet_split #(.NUM_THREADS(NT), .NUM_LANES(NL), .HDR_W(HW), .LANE_W(LW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_tmask(in_tmask), .in_hdr(in_hdr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tmask(out_tmask), .out_hdr(out_hdr),
    .out_data(out_data), .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] lane_word(input logic [31:0] seed, input int i);
    return {seed, 32'hC0DE_0000 | 32'(i), ~seed ^ 32'(i * 7 + 1)};
  endfunction

  function automatic logic [NT*LW-1:0] make_data(input logic [31:0] seed);
    logic [NT*LW-1:0] d;
    for (int i = 0; i < NT; i++) d[i*LW +: LW] = lane_word(seed, i);
    return d;
  endfunction

  function automatic logic [NL*LW-1:0] exp_slice(input logic [31:0] seed, input int k);
    return {lane_word(seed, 2*k + 1), lane_word(seed, 2*k)};
  endfunction

  task automatic drive_warp(input logic [NT-1:0] m, input logic [HW-1:0] h, input logic [31:0] seed);
    in_valid = 1'b1;
    in_tmask = m;
    in_hdr   = h;
    in_data  = make_data(seed);
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; in_tmask = '0; in_hdr = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_eop !== 1'b1) begin failures++; $display("FAIL reset_eop got=%b exp=1", out_eop); end
    checks++; if ({out_pid, out_sop, out_tmask} !== 5'b0) begin failures++; $display("FAIL reset_pid_sop_tmask got=%b exp=0", {out_pid, out_sop, out_tmask}); end
    checks++; if (out_hdr !== '0 || out_data !== '0) begin failures++; $display("FAIL reset_hdr_data got=%h/%h exp=0", out_hdr, out_data); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_mask;
    out_ready = 1'b1;
    drive_warp(8'hFF, 64'h1111_2222_3333_4444, 32'hA5A5_0001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_pid !== 2'(k)) begin failures++; $display("FAIL full_pid%0d got v=%b pid=%0d exp v=1 pid=%0d", k, out_valid, out_pid, k); end
      checks++; if (out_tmask !== 2'b11 || out_data !== exp_slice(32'hA5A5_0001, k)) begin failures++; $display("FAIL full_slice%0d got tmask=%b data=%h", k, out_tmask, out_data); end
      checks++; if (out_sop !== (k == 0) || out_eop !== (k == 3)) begin failures++; $display("FAIL full_flags%0d got sop=%b eop=%b exp sop=%b eop=%b", k, out_sop, out_eop, k == 0, k == 3); end
      checks++; if (in_ready !== (k == 3)) begin failures++; $display("FAIL full_in_ready%0d got=%b exp=%b", k, in_ready, k == 3); end
      if (k == 3) drive_warp(8'h03, 64'hBEEF_0000_0000_0002, 32'h0000_0777);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pid !== 2'd0 || out_sop !== 1'b1 || out_eop !== 1'b1) begin failures++; $display("FAIL b2b_second got v=%b pid=%0d sop=%b eop=%b exp 1/0/1/1", out_valid, out_pid, out_sop, out_eop); end
    checks++; if (out_hdr !== 64'hBEEF_0000_0000_0002 || out_data !== exp_slice(32'h0000_0777, 0)) begin failures++; $display("FAIL b2b_payload got hdr=%h", out_hdr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_single_middle;
    drive_warp(8'h30, 64'h0000_0000_0000_0030, 32'h1357_9BDF);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pid !== 2'd2 || out_tmask !== 2'b11) begin failures++; $display("FAIL mid_pid got v=%b pid=%0d tmask=%b exp 1/2/11", out_valid, out_pid, out_tmask); end
    checks++; if (out_sop !== 1'b1 || out_eop !== 1'b1) begin failures++; $display("FAIL mid_flags got sop=%b eop=%b exp 1/1", out_sop, out_eop); end
    checks++; if (out_data !== exp_slice(32'h1357_9BDF, 2)) begin failures++; $display("FAIL mid_data got=%h exp=%h", out_data, exp_slice(32'h1357_9BDF, 2)); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_single got v=%b exp=0", out_valid); end
  endtask

  task automatic test_sparse;
    drive_warp(8'h81, 64'h8181, 32'h2468_ACE0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_pid !== 2'd0 || out_tmask !== 2'b01 || out_sop !== 1'b1 || out_eop !== 1'b0) begin failures++; $display("FAIL sparse_first got pid=%0d tmask=%b sop=%b eop=%b exp 0/01/1/0", out_pid, out_tmask, out_sop, out_eop); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pid !== 2'd3 || out_tmask !== 2'b10 || out_sop !== 1'b0 || out_eop !== 1'b1) begin failures++; $display("FAIL sparse_last got v=%b pid=%0d tmask=%b sop=%b eop=%b exp 1/3/10/0/1", out_valid, out_pid, out_tmask, out_sop, out_eop); end
    checks++; if (out_data !== exp_slice(32'h2468_ACE0, 3)) begin failures++; $display("FAIL sparse_data got=%h", out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sparse_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_empty;
    drive_warp(8'h00, 64'hE0E0_E0E0_0000_0001, 32'h0F0F_0F0F);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pid !== 2'd0 || out_tmask !== 2'b00) begin failures++; $display("FAIL empty_pkt got v=%b pid=%0d tmask=%b exp 1/0/00", out_valid, out_pid, out_tmask); end
    checks++; if (out_sop !== 1'b1 || out_eop !== 1'b1 || out_hdr !== 64'hE0E0_E0E0_0000_0001) begin failures++; $display("FAIL empty_flags got sop=%b eop=%b hdr=%h", out_sop, out_eop, out_hdr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure;
    drive_warp(8'hFF, 64'hB00B_B00B_0000_00FF, 32'h5555_AAAA);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_pid !== 2'd1) begin failures++; $display("FAIL bp_start got pid=%0d exp=1", out_pid); end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_pid !== 2'd1 || out_tmask !== 2'b11 || out_sop !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got v=%b pid=%0d tmask=%b sop=%b", c, out_valid, out_pid, out_tmask, out_sop); end
      checks++; if (out_data !== exp_slice(32'h5555_AAAA, 1) || out_hdr !== 64'hB00B_B00B_0000_00FF) begin failures++; $display("FAIL bp_payload%0d got hdr=%h", c, out_hdr); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d got=%b exp=0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_pid !== 2'd2 || out_data !== exp_slice(32'h5555_AAAA, 2)) begin failures++; $display("FAIL bp_resume got pid=%0d exp=2", out_pid); end
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    drive_warp(8'hFF, 64'hDEAD, 32'h7777_0000);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_pid !== 2'd2) begin failures++; $display("FAIL rst_mid_pre got pid=%0d exp=2", out_pid); end
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_async got v=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_idle got v=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    drive_warp(8'h0C, 64'h0C0C, 32'h3333_1111);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pid !== 2'd1 || out_tmask !== 2'b11 || out_sop !== 1'b1 || out_eop !== 1'b1) begin failures++; $display("FAIL rst_mid_new got v=%b pid=%0d tmask=%b sop=%b eop=%b exp 1/1/11/1/1", out_valid, out_pid, out_tmask, out_sop, out_eop); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_drain got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_single_middle();
    test_sparse();
    test_empty();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
